// File: rtl/xmem_read_master.sv
// xmem_read_master: responder end of the rmst command / user-buffer protocol.
// Takes a read command (base, length), issues pipelined word reads on an
// Avalon-MM-style master port and buffers returned words in a show-ahead FIFO
// that the tile loader pops. One instance per in_fm / weight / out_fm channel.
// Optional build macro RMST_UNDERFLOW_CHK_EN adds the sticky rmst_err_underflow
// output (pop on empty FIFO, or readdatavalid with nothing outstanding).
module xmem_read_master #(
    parameter int XAW        = 32,
    parameter int XDW        = 128,
    parameter int FIFO_DEPTH = 32,
    parameter int FIFO_AW    = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rmst_fixed_location,
    input  logic [XAW-1:0] rmst_read_base,
    input  logic [XAW-1:0] rmst_read_length,
    input  logic           rmst_go,
    output logic           rmst_done,
    input  logic           rmst_user_read_buffer,
    output logic [XDW-1:0] rmst_user_buffer_data,
    output logic           rmst_user_data_available,
    output logic [XAW-1:0] master_address,
    output logic           master_read,
    input  logic           master_waitrequest,
    input  logic [XDW-1:0] master_readdata,
    input  logic           master_readdatavalid
`ifdef RMST_UNDERFLOW_CHK_EN
    ,
    output logic           rmst_err_underflow
`endif
);

    localparam int BPW    = XDW / 8;
    localparam int BPW_LG = $clog2(BPW);
    localparam logic [XAW-1:0]     ADDR_MASK = ~XAW'(BPW - 1);
    localparam logic [XAW-1:0]     ADDR_STEP = XAW'(BPW);
    localparam logic [XAW-1:0]     ONE_XAW   = XAW'(1);
    localparam logic [FIFO_AW:0]   ONE_CNT   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] ONE_PTR   = FIFO_AW'(1);
    localparam logic [FIFO_AW+1:0] DEPTH_W   = (FIFO_AW + 2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

    state_t             state_q,   state_d;
    logic [XAW-1:0]     addr_q,    addr_d;
    logic [XAW-1:0]     total_q,   total_d;
    logic [XAW-1:0]     issued_q,  issued_d;
    logic               fixed_q,   fixed_d;
    logic [FIFO_AW:0]   outst_q,   outst_d;
    logic [FIFO_AW:0]   used_q,    used_d;
    logic [FIFO_AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic               read_q,    read_d;
    logic               done_q,    done_d;
`ifdef RMST_UNDERFLOW_CHK_EN
    logic               err_q,     err_d;
`endif

    logic [XDW-1:0]     fifo_mem [FIFO_DEPTH];
    logic               accept;
    logic               push;
    logic               pop;
    logic [FIFO_AW+1:0] credit_sum;

    // Handshake qualifiers: stale returns and empty pops are dropped here.
    always_comb begin
        accept = read_q && !master_waitrequest;
        push   = master_readdatavalid && (outst_q != '0);
        pop    = rmst_user_read_buffer && (used_q != '0);
    end

    // Next-state logic for the command FSM, counters, FIFO pointers and outputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d    = state_q;
        addr_d     = addr_q;
        total_d    = total_q;
        issued_d   = issued_q;
        fixed_d    = fixed_q;
        outst_d    = outst_q;
        used_d     = used_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
        if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;

        unique case ({push, pop})
            2'b10:   used_d = used_q + ONE_CNT;
            2'b01:   used_d = used_q - ONE_CNT;
            default: used_d = used_q;
        endcase

        unique case ({accept, push})
            2'b10:   outst_d = outst_q + ONE_CNT;
            2'b01:   outst_d = outst_q - ONE_CNT;
            default: outst_d = outst_q;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (rmst_go) begin
                    addr_d   = rmst_read_base & ADDR_MASK;
                    total_d  = rmst_read_length >> BPW_LG;
                    fixed_d  = rmst_fixed_location;
                    issued_d = '0;
                    state_d  = ((rmst_read_length >> BPW_LG) == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (accept) begin
                    issued_d = issued_q + ONE_XAW;
                    if (!fixed_q) addr_d = addr_q + ADDR_STEP;
                    if (issued_d == total_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Exit on the post-update values so the final pop completes the drain at once.
                if (outst_d == '0 && used_d == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        done_d = (state_q == ST_DONE);

        // Room counts words already buffered plus words still in flight.
        credit_sum = {1'b0, used_d} + {1'b0, outst_d};
        read_d = (state_d == ST_READ) && (issued_d < total_d) && (credit_sum < DEPTH_W);
        // A stalled request must stay on the bus unchanged until accepted.
        if (read_q && master_waitrequest) read_d = 1'b1;
    end

`ifdef RMST_UNDERFLOW_CHK_EN
    // Sticky underflow flag: a new command clears it, a bad event in the same cycle wins.
    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && rmst_go) err_d = 1'b0;
        if ((rmst_user_read_buffer && used_q == '0) ||
            (master_readdatavalid && outst_q == '0)) err_d = 1'b1;
    end
`endif

    // State and control registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            total_q  <= '0;
            issued_q <= '0;
            fixed_q  <= 1'b0;
            outst_q  <= '0;
            used_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            read_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef RMST_UNDERFLOW_CHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            addr_q   <= addr_d;
            total_q  <= total_d;
            issued_q <= issued_d;
            fixed_q  <= fixed_d;
            outst_q  <= outst_d;
            used_q   <= used_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            read_q   <= read_d;
            done_q   <= done_d;
`ifdef RMST_UNDERFLOW_CHK_EN
            err_q    <= err_d;
`endif
        end
    end

    // FIFO storage: written on accepted returns only.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the head output is gated by occupancy instead.
        if (push) fifo_mem[wr_ptr_q] <= master_readdata;
    end

    assign master_read              = read_q;
    assign master_address           = addr_q;
    assign rmst_done                = done_q;
    assign rmst_user_data_available = (used_q != '0);
    assign rmst_user_buffer_data    = (used_q != '0) ? fifo_mem[rd_ptr_q] : '0;
`ifdef RMST_UNDERFLOW_CHK_EN
    assign rmst_err_underflow       = err_q;
`endif

endmodule
